// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared FSM state type and chip-select width helper for spi_master
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // A single chip select still needs a one-bit selector port.
  function automatic int cs_width(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// ============================================================================
// spi_tick_gen : half-period tick, one pulse every div+1 clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_tick_gen #(
  parameter int DIVW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            restart,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIVW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// spi_master : SPI master, configurable mode/divisor per transfer, NCS selects
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCS   = 4,
  parameter  int DIVW  = 8,
  localparam int CSW   = cs_width(NCS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  input  logic [CSW-1:0]   cs_sel,
  input  logic [DIVW-1:0]  div,
  input  logic             cpol,
  input  logic             cpha,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [NCS-1:0]   cs_n,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int ECW = $clog2(2 * WIDTH);

  state_t           state;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [DIVW-1:0]  div_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [ECW-1:0]   edge_cnt;
  logic [NCS-1:0]   cs_dec;
  logic             accept;
  logic             tick;

  assign accept = write && (state == IDLE);

  spi_tick_gen #(.DIVW(DIVW)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (accept),
    .div     (div_q),
    .tick    (tick)
  );

  // Out-of-range selectors match no line, so every cs_n bit stays high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= '0;
      rx       <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= '1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (write) begin
            state    <= SETUP;
            div_q    <= div;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            sck      <= cpol;
            cs_n     <= cs_dec;
            busy     <= 1'b1;
            edge_cnt <= '0;
            rx       <= '0;
            // Mode 0 puts the MSB on the line before the first edge;
            // mode 1 drives it on the leading edge instead.
            if (cpha) begin
              tx   <= din;
              mosi <= 1'b0;
            end else begin
              tx   <= {din[WIDTH-2:0], 1'b0};
              mosi <= din[WIDTH-1];
            end
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sck      <= ~sck;
            edge_cnt <= edge_cnt + ECW'(1);
            if (edge_cnt[0] == cpha_q) begin
              rx <= {rx[WIDTH-2:0], miso};
            end else begin
              mosi <= tx[WIDTH-1];
              tx   <= {tx[WIDTH-2:0], 1'b0};
            end
            if (edge_cnt == ECW'(2 * WIDTH - 1)) begin
              state <= HOLD;
              sck   <= cpol_q;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state <= GAP;
            cs_n  <= '1;
          end
        end
        GAP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dout  <= rx;
            mosi  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// tb_spi_master : table-driven transfers with a dout/latency scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

  // NCS=5 gives a 3-bit selector, so cs_sel=5 is a representable out-of-range value.
  localparam int WIDTH = 32;
  localparam int NCS   = 5;
  localparam int DIVW  = 8;
  localparam int CSW   = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             write = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic [CSW-1:0]   cs_sel = '0;
  logic [DIVW-1:0]  div   = '0;
  logic             cpol  = 1'b0;
  logic             cpha  = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;
  logic [NCS-1:0]   cs_n;
  logic             sck;
  logic             mosi;
  logic             miso;
  int               miso_mode = 0;

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

  spi_master #(.WIDTH(WIDTH), .NCS(NCS), .DIVW(DIVW)) dut (
    .clock  (clock),
    .reset  (reset),
    .write  (write),
    .din    (din),
    .cs_sel (cs_sel),
    .div    (div),
    .cpol   (cpol),
    .cpha   (cpha),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .cs_n   (cs_n),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] din;
    int          cs;
    int          dv;
    bit          pol;
    bit          pha;
    int          mm;     // 0 loopback, 1 miso high, 2 miso low
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    int          lat;
  } sb_t;

  vec_t tbl[5];
  sb_t  sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NCS-1:0] cs_exp(input int cs);
    logic [NCS-1:0] m;
    m = {NCS{1'b1}};
    if (cs < NCS) m[cs] = 1'b0;
    return m;
  endfunction

  task automatic issue(input vec_t v);
    din       = v.din;
    cs_sel    = CSW'(v.cs);
    div       = DIVW'(v.dv);
    cpol      = v.pol;
    cpha      = v.pha;
    miso_mode = v.mm;
    write     = 1'b1;
    sb.push_back('{v.exp, (2 * WIDTH + 3) * (v.dv + 1) + 1});
  endtask

  // mode 0 plain, 1 ignored mid-transfer write, 2 reset at clock 20, 3 chain nxt in done cycle
  task automatic run(input vec_t v, input int mode, input vec_t nxt);
    int   k, rises, last_t, half_bad, cs_bad, extra, hold_end;
    bit   got;
    logic prev;
    sb_t  e;
    k = 0; rises = 0; last_t = -1; half_bad = 0; cs_bad = 0; extra = 0; got = 0; prev = 1'b0;
    hold_end = (2 * WIDTH + 2) * (v.dv + 1);
    while (!got && k < 3000) begin
      @(posedge clock); #1; k++;
      if (k == 1) begin
        write = 1'b0;
        check("busy_rise", busy, 1);
        check("cs_setup", cs_n, cs_exp(v.cs));
        check("sck_idle", sck, v.pol);
        check("done_low", done, 0);
        prev = sck;
      end else if (sck !== prev) begin
        if (sck) rises++;
        if (last_t >= 0 && (k - last_t) != v.dv + 1) half_bad++;
        last_t = k;
        prev = sck;
      end
      if (!done) begin
        if (k <= hold_end) begin
          if (cs_n !== cs_exp(v.cs)) cs_bad++;
        end else if (cs_n !== {NCS{1'b1}}) cs_bad++;
      end
      if (mode == 1 && k == 10) begin write = 1'b1; din = '0; end
      if (mode == 1 && k == 11) begin write = 1'b0; din = v.din; end
      if (mode == 2 && k == 20) begin
        reset = 1'b1;
        #1;
        check("rst_cs", cs_n, {NCS{1'b1}});
        check("rst_sck", sck, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (300) begin
          @(posedge clock); #1;
          if (done) extra++;
        end
        check("rst_no_done", extra, 0);
        if (sb.size() > 0) e = sb.pop_front();
        return;
      end
      if (done) got = 1'b1;
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    check("dout", dout, e.dout);
    check("latency", k, e.lat);
    check("cs_done", cs_n, {NCS{1'b1}});
    check("busy_done", busy, 0);
    check("sck_rises", rises, WIDTH);
    check("half_period", half_bad, 0);
    check("cs_window", cs_bad, 0);
    if (mode == 3) begin
      issue(nxt);
      return;
    end
    @(posedge clock); #1;
    check("done_pulse", done, 0);
    if (mode == 1) begin
      repeat (150) begin
        @(posedge clock); #1;
        if (done) extra++;
      end
      check("single_done", extra, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vm, vr, b1, b2;
    tbl[0] = '{32'hA5A5F00F, 0, 0, 1'b0, 1'b0, 0, 32'hA5A5F00F};
    tbl[1] = '{32'h12345678, 1, 3, 1'b1, 1'b1, 1, 32'hFFFFFFFF};
    tbl[2] = '{32'h0F0F1234, 2, 1, 1'b0, 1'b1, 0, 32'h0F0F1234};
    tbl[3] = '{32'h80000001, 5, 0, 1'b1, 1'b0, 0, 32'h80000001};
    tbl[4] = '{32'h13572468, 4, 2, 1'b0, 1'b0, 2, 32'h00000000};
    vm     = '{32'hDEADBEEF, 1, 0, 1'b0, 1'b0, 0, 32'hDEADBEEF};
    b1     = '{32'hC3C3_0F0F, 3, 0, 1'b0, 1'b1, 0, 32'hC3C30F0F};
    b2     = '{32'h5A5A_1111, 0, 0, 1'b0, 1'b0, 0, 32'h5A5A1111};
    vr     = '{32'hFFFF0000, 2, 0, 1'b1, 1'b0, 0, 32'hFFFF0000};

    repeat (3) @(posedge clock);
    #1;
    check("reset_cs", cs_n, {NCS{1'b1}});
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dout", dout, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i]);
      run(tbl[i], 0, tbl[i]);
      check("idle_mosi", mosi, 0);
    end

    issue(vm);
    run(vm, 1, vm);

    issue(b1);
    run(b1, 3, b2);
    run(b2, 0, b2);

    issue(vr);
    run(vr, 2, vr);
    @(posedge clock); #1;
    issue(tbl[0]);
    run(tbl[0], 0, tbl[0]);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
